// File: rtl/div_arb_sched_if.sv
// Handshake bundle for div_arb_sched: two divide requesters in, one shared result stream out.
interface div_arb_sched_if #(
  parameter int unsigned WIDTH = 32
);
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [WIDTH-1:0] req_a0;
  logic [WIDTH-1:0] req_b0;
  logic [WIDTH-1:0] req_a1;
  logic [WIDTH-1:0] req_b1;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_quot;
  logic [WIDTH-1:0] rsp_rem;
  logic             rsp_dbz;
  logic             busy;

  modport master (
    output req_valid, req_a0, req_b0, req_a1, req_b1, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_quot, rsp_rem, rsp_dbz, busy
  );

  modport slave (
    input  req_valid, req_a0, req_b0, req_a1, req_b1, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_quot, rsp_rem, rsp_dbz, busy
  );
endinterface

// File: rtl/div_arb_sched.sv
// Round-robin shared restoring divider for two requesters (IDLE -> CALC -> DONE).
// Optional DIV_ARB_BYPASS_EN: b==1 and a<b finish without iterating.
module div_arb_sched #(
  parameter int unsigned WIDTH = 32
) (
  input logic             clk,
  input logic             rst_n,
  div_arb_sched_if.slave  bus_if
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e           r_state, w_state_d;
  logic             r_last, w_last_d;
  logic [CntW-1:0]  r_cnt, w_cnt_d;
  logic [WIDTH-1:0] r_div, w_div_d;
  logic [WIDTH-1:0] r_quot, w_quot_d;
  logic [WIDTH-1:0] r_rem, w_rem_d;
  logic             r_id, w_id_d;
  logic             r_dbz, w_dbz_d;

  logic [1:0]       w_grant;
  logic [1:0]       w_ready;
  logic             w_sel;
  logic [WIDTH-1:0] w_a, w_b;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH-1:0] w_diff;
  logic             w_ge;

  // Round-robin: on contention the requester not granted last wins.
  always_comb begin
    w_grant = 2'b00;
    unique case (bus_if.req_valid)
      2'b01:   w_grant = 2'b01;
      2'b10:   w_grant = 2'b10;
      2'b11:   w_grant = r_last ? 2'b01 : 2'b10;
      default: w_grant = 2'b00;
    endcase
  end

  assign w_sel = w_grant[1];
  assign w_a   = w_sel ? bus_if.req_a1 : bus_if.req_a0;
  assign w_b   = w_sel ? bus_if.req_b1 : bus_if.req_b0;

  // Partial remainder shifted left with the next dividend bit from the quotient register.
  assign w_shift = {r_rem, r_quot[WIDTH-1]};
  assign w_ge    = (w_shift >= {1'b0, r_div});
  assign w_diff  = w_shift[WIDTH-1:0] - r_div;

  always_comb begin
    w_state_d = r_state;
    w_last_d  = r_last;
    w_cnt_d   = r_cnt;
    w_div_d   = r_div;
    w_quot_d  = r_quot;
    w_rem_d   = r_rem;
    w_id_d    = r_id;
    w_dbz_d   = r_dbz;
    w_ready   = 2'b00;

    unique case (r_state)
      StIdle: begin
        if (rst_n && (w_grant != 2'b00)) begin
          w_ready  = w_grant;
          w_last_d = w_sel;
          w_id_d   = w_sel;
          if (w_b == '0) begin
            w_state_d = StDone;
            w_quot_d  = '1;
            w_rem_d   = w_a;
            w_dbz_d   = 1'b1;
          end
`ifdef DIV_ARB_BYPASS_EN
          else if (w_b == WIDTH'(1)) begin
            w_state_d = StDone;
            w_quot_d  = w_a;
            w_rem_d   = '0;
            w_dbz_d   = 1'b0;
          end else if (w_a < w_b) begin
            w_state_d = StDone;
            w_quot_d  = '0;
            w_rem_d   = w_a;
            w_dbz_d   = 1'b0;
          end
`endif
          else begin
            w_state_d = StCalc;
            w_quot_d  = w_a;
            w_rem_d   = '0;
            w_div_d   = w_b;
            w_dbz_d   = 1'b0;
            w_cnt_d   = CntW'(WIDTH);
          end
        end
      end
      StCalc: begin
        w_rem_d  = w_ge ? w_diff : w_shift[WIDTH-1:0];
        w_quot_d = {r_quot[WIDTH-2:0], w_ge};
        w_cnt_d  = r_cnt - CntW'(1);
        if (r_cnt == CntW'(1)) begin
          w_state_d = StDone;
        end
      end
      StDone: begin
        if (bus_if.rsp_ready) begin
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_last  <= 1'b1;
      r_cnt   <= '0;
      r_div   <= '0;
      r_quot  <= '0;
      r_rem   <= '0;
      r_id    <= 1'b0;
      r_dbz   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_last  <= w_last_d;
      r_cnt   <= w_cnt_d;
      r_div   <= w_div_d;
      r_quot  <= w_quot_d;
      r_rem   <= w_rem_d;
      r_id    <= w_id_d;
      r_dbz   <= w_dbz_d;
    end
  end

  assign bus_if.req_ready = w_ready;
  assign bus_if.rsp_valid = (r_state == StDone);
  assign bus_if.busy      = (r_state != StIdle);
  assign bus_if.rsp_id    = r_id;
  assign bus_if.rsp_quot  = r_quot;
  assign bus_if.rsp_rem   = r_rem;
  assign bus_if.rsp_dbz   = r_dbz;

endmodule

// File: tb/tb_div_arb_sched.sv
// Randomized bench for div_arb_sched against a queue-based arithmetic reference model.
module tb_div_arb_sched;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned W66   = 66;

  logic clk;
  logic rst_n;

  div_arb_sched_if #(.WIDTH(WIDTH)) u_if ();
  div_arb_sched_if #(.WIDTH(W66))   u_if66 ();

  div_arb_sched #(.WIDTH(WIDTH)) u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_if (u_if.slave)
  );

  div_arb_sched #(.WIDTH(W66)) u_dut66 (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_if (u_if66.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } op_t;

  int n_tests = 0;
  int n_fail  = 0;

  op_t q0[$];
  op_t q1[$];
  bit  pres0, pres1;
  bit  m_last;
  bit  fl_active;
  bit  fl_seen;
  bit  fl_id;
  op_t fl_op;
  int  fl_acc;
  int  fl_vcnt;
  int  cyc;

  task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic int exp_lat(input op_t o);
    if (o.b == '0) return 1;
`ifdef DIV_ARB_BYPASS_EN
    if (o.b == WIDTH'(1) || o.a < o.b) return 1;
`endif
    return WIDTH + 1;
  endfunction

  function automatic logic [WIDTH-1:0] exp_quot(input op_t o);
    if (o.b == '0) return '1;
    return o.a / o.b;
  endfunction

  function automatic logic [WIDTH-1:0] exp_rem(input op_t o);
    if (o.b == '0) return o.a;
    return o.a % o.b;
  endfunction

  function automatic logic [WIDTH-1:0] rnd_w();
    logic [127:0] t;
    t = {$urandom, $urandom, $urandom, $urandom};
    return t[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] rnd_opnd();
    case ($urandom_range(7))
      0:       return '0;
      1:       return WIDTH'(1);
      2, 3:    return WIDTH'($urandom_range(1, 1000));
      default: return rnd_w() >> $urandom_range(0, WIDTH - 1);
    endcase
  endfunction

  function automatic op_t mk(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    op_t o;
    o.a = a;
    o.b = b;
    return o;
  endfunction

  // Drives both request queues and checks grants, latency and results cycle by cycle.
  task automatic run_ops(input int budget, input int ready_pct, input int present_pct,
                         input int hold);
    int  n;
    logic [1:0] exp_rdy;
    op_t o;
    n = 0;
    while (q0.size() > 0 || q1.size() > 0 || pres0 || pres1 || fl_active) begin
      @(negedge clk);
      cyc++;
      n++;
      if (n > budget) begin
        check_eq("timeout", 1, 0);
        break;
      end
      if (!pres0 && q0.size() > 0 && $urandom_range(99) < present_pct) pres0 = 1'b1;
      if (!pres1 && q1.size() > 0 && $urandom_range(99) < present_pct) pres1 = 1'b1;
      u_if.req_valid = {pres1, pres0};
      u_if.req_a0    = pres0 ? q0[0].a : rnd_w();
      u_if.req_b0    = pres0 ? q0[0].b : rnd_w();
      u_if.req_a1    = pres1 ? q1[0].a : rnd_w();
      u_if.req_b1    = pres1 ? q1[0].b : rnd_w();
      u_if.rsp_ready = (fl_vcnt >= hold) && ($urandom_range(99) < ready_pct);
      #1;
      exp_rdy = 2'b00;
      if (!fl_active) begin
        if (pres0 && pres1)  exp_rdy = m_last ? 2'b01 : 2'b10;
        else if (pres0)      exp_rdy = 2'b01;
        else if (pres1)      exp_rdy = 2'b10;
      end
      check_eq("req_ready", u_if.req_ready, exp_rdy);
      check_eq("busy", u_if.busy, fl_active);
      if (fl_active) begin
        if (u_if.rsp_valid) begin
          fl_vcnt++;
          if (!fl_seen) begin
            check_eq("latency", cyc - fl_acc, exp_lat(fl_op));
            fl_seen = 1'b1;
          end
          check_eq("rsp_id", u_if.rsp_id, fl_id);
          check_eq("rsp_quot", u_if.rsp_quot, exp_quot(fl_op));
          check_eq("rsp_rem", u_if.rsp_rem, exp_rem(fl_op));
          check_eq("rsp_dbz", u_if.rsp_dbz, fl_op.b == '0);
          if (u_if.rsp_ready) fl_active = 1'b0;
        end
      end else begin
        check_eq("spurious_valid", u_if.rsp_valid, 0);
      end
      if (exp_rdy != 2'b00) begin
        if (exp_rdy[1]) begin
          o = q1.pop_front();
          pres1 = 1'b0;
        end else begin
          o = q0.pop_front();
          pres0 = 1'b0;
        end
        m_last    = exp_rdy[1];
        fl_active = 1'b1;
        fl_seen   = 1'b0;
        fl_id     = exp_rdy[1];
        fl_op     = o;
        fl_acc    = cyc;
        fl_vcnt   = 0;
      end
    end
    @(negedge clk);
    u_if.req_valid = 2'b00;
    u_if.rsp_ready = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_rsp_valid"}, u_if.rsp_valid, 0);
    check_eq({tag, "_req_ready"}, u_if.req_ready, 0);
    check_eq({tag, "_busy"}, u_if.busy, 0);
    check_eq({tag, "_rsp_id"}, u_if.rsp_id, 0);
    check_eq({tag, "_quot"}, u_if.rsp_quot, 0);
    check_eq({tag, "_rem"}, u_if.rsp_rem, 0);
    check_eq({tag, "_dbz"}, u_if.rsp_dbz, 0);
  endtask

  initial begin
    int lat;
    int stale;
    rst_n          = 1'b0;
    u_if.req_valid = 2'b11;
    u_if.req_a0    = '0;
    u_if.req_b0    = '0;
    u_if.req_a1    = '0;
    u_if.req_b1    = '0;
    u_if.rsp_ready = 1'b0;
    u_if66.req_valid = 2'b00;
    u_if66.req_a0    = '0;
    u_if66.req_b0    = '0;
    u_if66.req_a1    = '0;
    u_if66.req_b1    = '0;
    u_if66.rsp_ready = 1'b0;
    pres0 = 0; pres1 = 0; m_last = 1'b1; fl_active = 0; fl_seen = 0; fl_vcnt = 0; cyc = 0;

    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    u_if.req_valid = 2'b00;
    rst_n = 1'b1;

    // Contention from reset with a held-off response.
    q0.push_back(mk(100, 7));
    q1.push_back(mk(100, 9));
    run_ops(500, 100, 100, 5);

    q0.push_back(mk(1, 1));
    run_ops(200, 100, 100, 0);
    q0.push_back(mk(WIDTH'('h2537f12), WIDTH'('h7322a)));
    q1.push_back(mk(WIDTH'('h1234), '0));
    run_ops(300, 100, 100, 0);

    q0.push_back(mk(0, 5));
    q1.push_back(mk(7, 7));
    q0.push_back(mk(3, 10));
    q1.push_back(mk('1, 1));
    q0.push_back(mk('1, '1));
    q1.push_back(mk('1, 2));
    q0.push_back(mk(0, 0));
    run_ops(1000, 70, 80, 2);

    // 66-bit instance: same operands, same results.
    @(negedge clk);
    u_if66.req_valid = 2'b01;
    u_if66.req_a0    = W66'('h2537f12);
    u_if66.req_b0    = W66'('h7322a);
    #1;
    check_eq("w66_ready", u_if66.req_ready, 2'b01);
    @(negedge clk);
    u_if66.req_valid = 2'b00;
    lat = 1;
    while (!u_if66.rsp_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check_eq("w66_latency", lat, W66 + 1);
    check_eq("w66_quot", u_if66.rsp_quot, 'h52);
    check_eq("w66_rem", u_if66.rsp_rem, 'h56d9e);
    check_eq("w66_dbz", u_if66.rsp_dbz, 0);
    u_if66.rsp_ready = 1'b1;
    @(negedge clk);
    u_if66.rsp_ready = 1'b0;

    // Reset in the middle of an iterative divide.
    @(negedge clk);
    u_if.req_valid = 2'b01;
    u_if.req_a0    = WIDTH'('h2537f12);
    u_if.req_b0    = WIDTH'('h7322a);
    #1;
    check_eq("mid_ready", u_if.req_ready, 2'b01);
    @(negedge clk);
    u_if.req_valid = 2'b00;
    repeat (5) @(negedge clk);
    check_eq("mid_busy", u_if.busy, 1);
    rst_n = 1'b0;
    u_if.req_valid = 2'b11;
    #1;
    check_reset_outputs("mid_rst");
    @(negedge clk);
    u_if.req_valid = 2'b00;
    rst_n  = 1'b1;
    m_last = 1'b1;
    stale  = 0;
    repeat (WIDTH + 5) begin
      @(negedge clk);
      if (u_if.rsp_valid || u_if.busy) stale++;
    end
    check_eq("no_stale", stale, 0);
    q0.push_back(mk(WIDTH'('h2537f12), WIDTH'('h7322a)));
    run_ops(200, 100, 100, 0);

    // 100 random operations spread over both requesters.
    for (int i = 0; i < 100; i++) begin
      if ($urandom_range(1) == 0) q0.push_back(mk(rnd_opnd(), rnd_opnd()));
      else                        q1.push_back(mk(rnd_opnd(), rnd_opnd()));
    end
    run_ops(20000, 60, 70, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/div_arb_sched.md
DIV_ARB_SCHED -- requirements
Module: div_arb_sched

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width; legal range 2..66.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  reset, asynchronous, active-low; one clock and no other reset.
REQ-004 req_valid  input  2  per-requester divide request; bit i belongs to requester i.
REQ-005 req_ready  output  2  per-requester accept; a request transfers when req_valid[i] & req_ready[i].
REQ-006 req_a0, req_b0  input  WIDTH each  requester 0 dividend and divisor, unsigned.
REQ-007 req_a1, req_b1  input  WIDTH each  requester 1 dividend and divisor, unsigned.
REQ-008 rsp_valid  output  1  result available.
REQ-009 rsp_ready  input  1  result consumed when rsp_valid & rsp_ready.
REQ-010 rsp_id  output  1  index of the requester that owns the result.
REQ-011 rsp_quot, rsp_rem  output  WIDTH each  quotient a/b and remainder a%b.
REQ-012 rsp_dbz  output  1  divide-by-zero flag for the current result.
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 Block SHALL time-share one iterative restoring divider between 2 requesters through FSM states IDLE, CALC and DONE.
REQ-015 IDLE: req_ready SHALL be combinational, one-hot or zero, and high only for the granted requester; req_ready SHALL be 0 in CALC and DONE.
REQ-016 Arbitration SHALL be round-robin: with both requesters valid, grant the one not granted last; with one valid, grant it; last-grant pointer SHALL update on each accept.
REQ-017 On accept, a and b SHALL be latched; requester inputs are don't-care afterwards; IDLE->CALC, with the iteration counter loaded to WIDTH.
REQ-018 CALC SHALL resolve one quotient bit per cycle (MSB first) using a WIDTH+1-bit partial remainder, then move to DONE after WIDTH cycles.
REQ-019 Normal-path latency SHALL be WIDTH+1 cycles from the accept edge to the first cycle with rsp_valid=1.
REQ-020 DONE: rsp_valid=1; rsp_id, rsp_quot, rsp_rem and rsp_dbz SHALL hold stable until handshake; on handshake DONE->IDLE.
REQ-021 A new request SHALL NOT be granted in the same cycle as the response handshake; the earliest grant is in the next IDLE cycle.
REQ-022 Divisor 0: detected at accept, the block SHALL go IDLE->DONE directly (latency 1) with quot all-ones, rem = dividend and dbz=1.
REQ-023 rsp_dbz SHALL be 0 for every nonzero divisor.
REQ-024 Results SHALL be bit-exact against unsigned a/b and a%b at every WIDTH, including a=0, a<b and a=b.
REQ-025 A requester with req_valid high and no grant SHALL keep waiting; no request SHALL be dropped or reordered within one requester.

Reset
REQ-026 While rst_n=0: state=IDLE, rsp_valid=0, req_ready=0, busy=0, rsp_id=0, rsp_quot=0, rsp_rem=0, rsp_dbz=0, counter=0.
REQ-027 Last-grant pointer SHALL reset to 1, so requester 0 wins the first contention.
REQ-028 Reset asserted mid-CALC or mid-DONE SHALL abandon the operation; no response SHALL be issued for it after deassertion.

Configuration
REQ-029 Macro DIV_ARB_BYPASS_EN defined: the block SHALL skip CALC and reach DONE at latency 1 when b==1 (quot=a, rem=0) or when a<b (quot=0, rem=a).
REQ-030 Macro DIV_ARB_BYPASS_EN undefined: those cases SHALL take the full WIDTH+1 latency with identical result values; only the divide-by-zero path is short.

Verification
REQ-031 Requester 0: a=1, b=1 -> rsp_quot=1, rsp_rem=0, rsp_dbz=0, rsp_id=0, rsp_valid rising WIDTH+1 cycles after accept.
REQ-032 a=0x2537f12, b=0x7322a -> quot=0x52, rem=0x56d9e; repeat with WIDTH=66 and expect the same values.
REQ-033 b=0, a=0x1234 -> 1-cycle latency, quot=all-ones, rem=0x1234, dbz=1.
REQ-034 Both requesters valid from reset with a=100,b=7 (req0) and a=100,b=9 (req1) -> first response rsp_id=0 (14 rem 2), then rsp_id=1 (11 rem 1); hold rsp_ready=0 for 5 cycles and check outputs stay stable.
REQ-035 Assert rst_n=0 mid-CALC -> all outputs at reset values; no stale rsp_valid after release; the next request completes correctly.
REQ-036 Run 100 random (a,b) pairs from both requesters, with the macro both defined and undefined -> every result matches / and %; latency matches REQ-019/REQ-022/REQ-029/REQ-030.
